// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: the FSM state encoding, the
// RISC-V funct3 size/sign codes, and small decode helpers used at request
// accept time.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Loads accept B/H/W/BU/HU; stores only B/H/W.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        if (we) begin
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                    f3 == F3_BU || f3 == F3_HU);
        end
        return bad;
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (f3 == F3_H || f3 == F3_HU) begin
            bad = lane[0];
        end else if (f3 == F3_W) begin
            bad = (lane != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for the load/store unit.
//   Load path : picks the byte/half/word out of rd_word_i and sign- or
//               zero-extends it according to funct3_i.
//   Store path: replaces the addressed byte/half of old_word_i with the low
//               bits of wdata_i; a word store passes wdata_i straight through.
// Byte lane comes from lane_i; halfwords use lane_i[1] only and words ignore
// lane_i, so misaligned low bits are silently dropped here.
//
// Ports:
//   rd_word_i   in  32  word read from memory (load extraction source)
//   old_word_i  in  32  word captured before a sub-word store
//   wdata_i     in  32  store data (low bytes used for SB/SH)
//   lane_i      in  2   byte address bits [1:0]
//   funct3_i    in  3   RISC-V size/sign code
//   load_data_o out 32  extended load data (0 for unknown funct3)
//   merged_o    out 32  word to write back
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every output of a combinational block gets a default at the top,
    // so no path through the case statements can leave it unassigned and
    // infer a latch.
    always_comb begin
        byte_v = 8'h00;
        case (lane_i)
            2'd0: byte_v = rd_word_i[7:0];
            2'd1: byte_v = rd_word_i[15:8];
            2'd2: byte_v = rd_word_i[23:16];
            2'd3: byte_v = rd_word_i[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_W:    load_data_o = rd_word_i;
            F3_BU:   load_data_o = {24'h000000, byte_v};
            F3_HU:   load_data_o = {16'h0000, half_v};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        merged_o = old_word_i;
        case (funct3_i)
            F3_B:    merged_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
            F3_H:    merged_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
            F3_W:    merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word accesses
// on a word-wide data memory with combinational read data. Sub-word stores are
// done as read-modify-write because the memory only writes full words and
// returns 0 on RD while WE is high.
//
// FSM: IDLE -> READ -> (RESP | WRITE -> RESP), IDLE -> WRITE (SW),
//      IDLE -> RESP (error). RESP emits a one-cycle resp_valid pulse.
// Latency accept-edge to resp_valid: load 2, SW 2, SB/SH 3, error 1.
//
// Configuration:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                          rejected with resp_err and no memory access; when
//                          undefined, offending low address bits are ignored.
//
// Ports:
//   CLK         in  1       clock, rising edge
//   rst         in  1       synchronous active-high reset
//   req_valid   in  1       request present, held until accepted
//   req_ready   out 1       high only in IDLE
//   req_we      in  1       1 = store, 0 = load
//   req_funct3  in  3       size/sign code
//   req_addr    in  32      byte address (wraps modulo MEM_DEPTH words)
//   req_wdata   in  DATA_W  store data
//   resp_valid  out 1       one-cycle completion pulse
//   resp_rdata  out DATA_W  extended load data, 0 for stores/errors
//   resp_err    out 1       illegal funct3 (or misaligned, if enabled)
//   mem_A       out 32      zero-extended word index
//   mem_WD      out DATA_W  memory write data
//   mem_WE      out 1       memory write enable
//   mem_RD      in  DATA_W  combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = 10
) (
    input  logic              CLK,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic [31:0]       mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(MEM_DEPTH - 1);

    lsu_state_e        state_q, state_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_bad;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;
    logic [IDX_W-1:0]  word_idx;

    // Address bits above the memory index simply wrap; they are not checked.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    lsu_lane_align u_lane_align (
        .rd_word_i   (mem_RD),
        .old_word_i  (word_q),
        .wdata_i     (wdata_q),
        .lane_i      (addr_q[1:0]),
        .funct3_i    (funct3_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        req_bad = f3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
        req_bad = req_bad | misaligned(req_funct3, req_addr[1:0]);
`endif
    end

    // Next-state and capture logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[IDX_W+1:0];
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    // Sub-word store: keep the old word for the merge.
                    word_d  = mem_RD;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign word_idx   = addr_q[IDX_W+1:2] & IDX_MASK;
    assign mem_A      = {{(32-IDX_W){1'b0}}, word_idx};
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // The write strobe is gated by rst combinationally: a reset edge that
    // lands on the WRITE cycle must not commit the word.
    assign mem_WE = (state_q == S_WRITE) && !rst;
    assign mem_WD = (state_q == S_WRITE) ? merged : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        CLK;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem [0:1023];

    int n_checks;
    int n_errors;

    load_store_unit #(
        .DATA_W    (32),
        .MEM_DEPTH (1024),
        .IDX_W     (10)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word memory: combinational read, 0 on RD while writing, write on edge.
    assign mem_RD = mem_WE ? 32'h0 : mem[mem_A[9:0]];
    always @(posedge CLK) begin
        if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Issue one request at a negedge and follow it to its response.
    task automatic do_req(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          lat,
        output logic [31:0] rdata,
        output logic        err,
        output int          we_cnt,
        output logic [31:0] we_a,
        output logic [31:0] we_d,
        output logic [31:0] a_c1
    );
        we_cnt     = 0;
        we_a       = '0;
        we_d       = '0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge CLK);
        req_valid = 1'b0;
        a_c1      = mem_A;
        lat       = 1;
        while (!resp_valid && lat < 10) begin
            if (mem_WE) begin
                we_cnt++;
                we_a = mem_A;
                we_d = mem_WD;
            end
            @(negedge CLK);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (mem_WE) we_cnt++;
        @(negedge CLK);
    endtask

    int          lat;
    int          wec;
    logic [31:0] rd;
    logic        er;
    logic [31:0] wa;
    logic [31:0] wdv;
    logic [31:0] a1;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        repeat (3) @(negedge CLK);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_err", {31'b0, resp_err}, 32'd0);
        check("reset_we", {31'b0, mem_WE}, 32'd0);
        @(negedge CLK);

        // SW 0x10
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, wec, wa, wdv, a1);
        check("sw_lat", lat, 32'd2);
        check("sw_we_cnt", wec, 32'd1);
        check("sw_we_a", wa, 32'd4);
        check("sw_we_d", wdv, 32'hDEADBEEF);
        check("sw_err", {31'b0, er}, 32'd0);
        check("sw_rdata", rd, 32'h0);
        check("sw_mem4", mem[4], 32'hDEADBEEF);

        // Loads of DEADBEEF
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lb_rdata", rd, 32'hFFFFFFDE);
        check("lb_lat", lat, 32'd2);
        check("lb_no_write", wec, 32'd0);
        check("lb_read_a", a1, 32'd4);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lbu_rdata", rd, 32'h000000DE);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lhu_rdata", rd, 32'h0000BEEF);
        check("lhu_lat", lat, 32'd2);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lh_rdata", rd, 32'hFFFFDEAD);

        // SB 0x11 <- 0x55
        do_req(1'b1, 3'b000, 32'h11, 32'h00000055, lat, rd, er, wec, wa, wdv, a1);
        check("sb_lat", lat, 32'd3);
        check("sb_we_cnt", wec, 32'd1);
        check("sb_we_a", wa, 32'd4);
        check("sb_we_d", wdv, 32'hDEAD55EF);
        check("sb_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lw_after_sb", rd, 32'hDEAD55EF);

        // SH 0x12 <- 0x1234
        do_req(1'b1, 3'b001, 32'h12, 32'hABCD1234, lat, rd, er, wec, wa, wdv, a1);
        check("sh_lat", lat, 32'd3);
        check("sh_we_d", wdv, 32'h123455EF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("lw_after_sh", rd, 32'h123455EF);

        // Misaligned LW 0x12
        do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, er, wec, wa, wdv, a1);
`ifdef LSU_MISALIGN_CHECK_EN
        check("lw_mis_err", {31'b0, er}, 32'd1);
        check("lw_mis_rdata", rd, 32'h0);
        check("lw_mis_lat", lat, 32'd1);
        check("lw_mis_no_write", wec, 32'd0);
`else
        check("lw_mis_err", {31'b0, er}, 32'd0);
        check("lw_mis_rdata", rd, 32'h123455EF);
        check("lw_mis_lat", lat, 32'd2);
        check("lw_mis_read_a", a1, 32'd4);
`endif

        // Illegal funct3
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er, wec, wa, wdv, a1);
        check("ld_f3_011_err", {31'b0, er}, 32'd1);
        check("ld_f3_011_lat", lat, 32'd1);
        check("ld_f3_011_rdata", rd, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, lat, rd, er, wec, wa, wdv, a1);
        check("st_f3_100_err", {31'b0, er}, 32'd1);
        check("st_f3_100_no_write", wec, 32'd0);
        check("st_f3_100_mem4", mem[4], 32'h123455EF);

        // Reset during the WRITE cycle of an SB
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h12;
        req_wdata  = 32'h000000AA;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        check("rst_wr_we_before", {31'b0, mem_WE}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wr_we_gated", {31'b0, mem_WE}, 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        check("rst_wr_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_wr_ready", {31'b0, req_ready}, 32'd1);
        check("rst_wr_mem4", mem[4], 32'h123455EF);
        @(negedge CLK);
        check("rst_wr_resp_valid2", {31'b0, resp_valid}, 32'd0);

        // Back-to-back with req_valid held high; second address wraps
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        @(negedge CLK);
        req_addr = 32'h1010;
        check("b2b_ready_busy", {31'b0, req_ready}, 32'd0);
        @(negedge CLK);
        check("b2b_resp1_valid", {31'b0, resp_valid}, 32'd1);
        check("b2b_resp1_rdata", resp_rdata, 32'h123455EF);
        check("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
        @(negedge CLK);
        check("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
        check("b2b_resp_gap", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        req_valid = 1'b0;
        check("b2b_wrap_a", mem_A, 32'd4);
        check("b2b_read_state", {31'b0, resp_valid}, 32'd0);
        @(negedge CLK);
        check("b2b_resp2_valid", {31'b0, resp_valid}, 32'd1);
        check("b2b_resp2_rdata", resp_rdata, 32'h123455EF);
        @(negedge CLK);
        check("b2b_end_ready", {31'b0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/control path and the word-wide data memory.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the memory port.
- Loads are extracted and extended here. Sub-word stores run as a read-modify-write sequence, because the memory supports only whole-word writes and returns 0 on RD while WE=1.
- Has a small FSM with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- DATA_W, 32, data width; only 32 is supported.
- MEM_DEPTH, 1024, number of memory words.
- IDX_W, 10, clog2(MEM_DEPTH), word-index width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; held stable until accepted.
- req_ready  out  1  1 only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_A  out  32  word index, zero-extended: {22'b0, req_addr[IDX_W+1:2]}.
- mem_WD  out  32  write data.
- mem_WE  out  1  write enable.
- mem_RD  in  32  combinational read data.

Behaviour:
- Reset:
  - Synchronous. State=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; capture registers cleared.
  - mem_WE is gated by !rst, so no memory write happens on a reset edge, including reset during WRITE. Any in-flight operation is dropped with no response.
- Accept: in IDLE with req_valid=1, the request's addr/funct3/wdata/we are latched on the edge. Requests are ignored while not in IDLE (req_ready=0).
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on error; -> WRITE for SW; -> READ for loads, SB and SH.
  - READ: mem_WE=0, mem_A=latched index; mem_RD is captured at the edge.
    - Load -> RESP.
    - SB/SH -> WRITE.
  - WRITE: mem_WE=1 for exactly one cycle; mem_WD = captured word with the addressed byte/half replaced (addr[1:0] selects the lane). SW writes wdata directly. -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. req_ready=0 in RESP.
- Outside READ/WRITE: mem_WE=0, mem_WD=0, mem_A=latched index.
- Latency from the accept edge to the resp_valid cycle: load 2, SW 2, SB/SH 3, error 1.
- Extraction: lane = addr[1:0]; byte at bits [8*lane+7 : 8*lane], half at [16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Illegal funct3 raises resp_err with no memory access:
  - loads: 011, 110, 111;
  - stores: anything other than 000/001/010.
- Addresses with bits above IDX_W+1 set wrap modulo MEM_DEPTH (upper bits dropped); no error.
- Back-to-back requests: a new accept is possible in the IDLE cycle after RESP, i.e. at most one op per (latency+1) cycles.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE->RESP with resp_err=1, resp_rdata=0, no memory access.
- Undefined: the offending low address bits are ignored (half forced to addr[1], word to lane 0) and the access proceeds normally; resp_err reports only illegal funct3.

Decomposition:
- Shared package lsu_pkg:
  - state enum (IDLE, READ, WRITE, RESP);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One natural sub-module, lsu_lane_align (combinational), implementing:
  - load extraction/extension from (word, addr[1:0], funct3);
  - store merge of (old word, wdata, addr[1:0], funct3).
- The FSM stays in load_store_unit.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF -> mem_WE=1 with mem_A=4 in the cycle after accept; resp_valid 2 cycles after accept, resp_err=0.
- LB addr=0x13 on word 0xDEADBEEF -> resp_rdata=0xFFFFFFDE; LBU same -> 0x000000DE; LHU addr=0x10 -> 0x0000BEEF; latency 2.
- SB addr=0x11 wdata=0x00000055 onto 0xDEADBEEF -> single WRITE of 0xDEAD55EF at index 4; latency 3; the word re-read by LW is 0xDEAD55EF.
- With LSU_MISALIGN_CHECK_EN: LW addr=0x12 -> resp_err=1, resp_rdata=0, mem_WE never asserted, latency 1. Without it: same request returns word index 4. funct3=011 load -> resp_err=1 in both builds.
- rst=1 during the WRITE cycle of an SB -> no write (memory word unchanged); resp_valid stays 0; req_ready=1 the next cycle.
- req_valid held high across a busy op -> the second request is accepted only after RESP; addr=0x1010 (beyond depth) -> mem_A=4 (wrap).
